// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, drives them to an external
// combinational ALU, samples its outputs after a fixed latency and returns
// the result and flags over a valid/ready response stream.
module alu_cmd_issuer #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 3,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [2:0]        rsp_flags,
  output logic [OP_W-1:0]   rsp_op,
  output logic              busy,
  output logic [7:0]        issued_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 * DATA_W + OP_W;

  // Wait counter is 4 bits: ALU_LAT is limited to 1..15.
  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESPOND
  } state_t;

  state_t state_reg, state_next;

  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [ENTRY_W-1:0] head_entry;
  logic [3:0]         wait_cnt_reg;

  logic push, pop, capture, finish;

  // A push only happens against the registered ready, so the source never
  // sees a combinational path from our pop back to cmd_ready.
  assign push       = cmd_valid && cmd_ready;
  assign head_entry = fifo_mem[rd_ptr_reg];
  assign busy       = (state_reg != IDLE) || (count_reg != '0);

  // FIFO occupancy after this edge; simultaneous push and pop cancel out.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      cmd_ready  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      cmd_ready <= (count_next != CNT_W'(DEPTH));
    end
  end

  // Command storage; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {cmd_a, cmd_b, cmd_op};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and control strobes.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (wait_cnt_reg == 4'd0) begin
          capture    = 1'b1;
          state_next = RESPOND;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand drive, latency counter, response capture and completion count.
  // alu_* and rsp_* only change on pop/capture, so they hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
      wait_cnt_reg <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
      rsp_op       <= '0;
      issued_count <= '0;
    end else begin
      if (pop) begin
        alu_a        <= head_entry[ENTRY_W-1 -: DATA_W];
        alu_b        <= head_entry[OP_W +: DATA_W];
        alu_opcode   <= head_entry[OP_W-1:0];
        wait_cnt_reg <= LAT_INIT;
      end else if (state_reg == DRIVE && wait_cnt_reg != 4'd0) begin
        wait_cnt_reg <= wait_cnt_reg - 4'd1;
      end

      if (capture) begin
        rsp_result <= alu_result;
        rsp_flags  <= {alu_overflow, alu_carry, alu_zero};
        rsp_op     <= alu_opcode;
        rsp_valid  <= 1'b1;
      end else if (finish) begin
        rsp_valid    <= 1'b0;
        issued_count <= issued_count + 8'd1;
      end
    end
  end

endmodule
